// File: rtl/pc_fetch_ctrl.sv
// IF-stage program-counter controller: sequential step, redirect, stall, flush, misalign flag.
// Latency: a redirect taken without a stall appears on PC one edge later; all outputs registered.
// Backpressure: bubbleF freezes PC/valid/state; a redirect arriving under stall is parked until release.
module pc_fetch_ctrl #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] FLUSH_VEC  = '0,
  parameter int              INST_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubbleF,
  input  logic            flushF,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_target,
  output logic [XLEN-1:0] PC,
  output logic            pc_valid,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  // Low address bits that must be zero for an aligned instruction, and the sequential step.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(INST_BYTES);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pending, pending_d;
  logic [XLEN-1:0] pc_d;
  logic            valid_d;
  logic            misalign_d;
  logic [XLEN-1:0] misalign_addr_d;
  logic            load;
  logic [XLEN-1:0] load_tgt;

  // Next-state selection: stall beats flush beats live redirect beats the per-state action.
  always_comb begin
    state_d         = state;
    pending_d       = pending;
    pc_d            = PC;
    valid_d         = pc_valid;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr;
    load            = 1'b0;
    load_tgt        = '0;

    if (bubbleF) begin
      // Frozen fetch; only the pending slot may change (latest redirect wins).
      if (redir_valid) begin
        pending_d = redir_target;
        state_d   = HOLD;
      end
    end else if (flushF) begin
      // Squash: park the PC, drop validity, forget any parked redirect.
      pc_d      = FLUSH_VEC;
      valid_d   = 1'b0;
      pending_d = '0;
      state_d   = WAIT;
    end else if (redir_valid) begin
      // A live redirect supersedes anything parked in HOLD.
      load     = 1'b1;
      load_tgt = redir_target;
    end else begin
      case (state)
        BOOT: begin
          // First valid fetch is the reset vector itself.
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN:  pc_d = PC + STEP;
        HOLD: begin
          load     = 1'b1;
          load_tgt = pending;
        end
        WAIT: ;
        default: state_d = BOOT;
      endcase
    end

    // Misalignment is judged when a target actually lands in PC, not when it is parked.
    if (load) begin
      pc_d    = load_tgt & ~ALIGN_MASK;
      valid_d = 1'b1;
      state_d = RUN;
      if (|(load_tgt & ALIGN_MASK)) begin
        misalign_d      = 1'b1;
        misalign_addr_d = load_tgt;
      end
    end
  end

  // State and output registers; reset discards any parked redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pending       <= '0;
      PC            <= RESET_VEC;
      pc_valid      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state         <= state_d;
      pending       <= pending_d;
      PC            <= pc_d;
      pc_valid      <= valid_d;
      misalign      <= misalign_d;
      misalign_addr <= misalign_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: hand-computed expected PC/valid/misalign per edge.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// A distinct FLUSH_VEC is used so a flushed PC cannot be confused with the reset vector.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] FV = 32'h0000_0F00;

  logic        clk;
  logic        rst;
  logic        bubbleF;
  logic        flushF;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] PC;
  logic        pc_valid;
  logic        misalign;
  logic [31:0] misalign_addr;

  int vectors     = 0;
  int miscompares = 0;

  pc_fetch_ctrl #(
    .XLEN(32),
    .RESET_VEC(32'h0000_0000),
    .FLUSH_VEC(FV),
    .INST_BYTES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bubbleF(bubbleF),
    .flushF(flushF),
    .redir_valid(redir_valid),
    .redir_target(redir_target),
    .PC(PC),
    .pc_valid(pc_valid),
    .misalign(misalign),
    .misalign_addr(misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc_e, input logic v_e, input logic m_e);
    chk({tag, ".pc"}, PC, pc_e);
    chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, v_e});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_e});
  endtask

  task automatic drive(input logic b, input logic f, input logic rv, input logic [31:0] rt);
    bubbleF      = b;
    flushF       = f;
    redir_valid  = rv;
    redir_target = rt;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 32'h0);
    step();
    step();
    chk_pc("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.maddr", misalign_addr, 32'h0);
    rst = 1'b0;

    // 1: boot then sequential fetch
    step(); chk_pc("t1.e1", 32'h0, 1'b1, 1'b0);
    step(); chk_pc("t1.e2", 32'h4, 1'b1, 1'b0);
    step(); chk_pc("t1.e3", 32'h8, 1'b1, 1'b0);
    step(); chk_pc("t1.e4", 32'hC, 1'b1, 1'b0);
    step(); chk_pc("t1.e5", 32'h10, 1'b1, 1'b0);

    // 2: redirect captured under a 3-cycle stall
    drive(1, 0, 1, 32'h100); step(); chk_pc("t2.s1", 32'h10, 1'b1, 1'b0);
    drive(1, 0, 0, 32'h0);   step(); chk_pc("t2.s2", 32'h10, 1'b1, 1'b0);
    step(); chk_pc("t2.s3", 32'h10, 1'b1, 1'b0);
    drive(0, 0, 0, 32'h0);   step(); chk_pc("t2.rel", 32'h100, 1'b1, 1'b0);
    step(); chk_pc("t2.seq", 32'h104, 1'b1, 1'b0);

    // 3: newer pending overwrites older; live redirect beats pending
    drive(1, 0, 1, 32'h200); step(); chk_pc("t3.s1", 32'h104, 1'b1, 1'b0);
    drive(1, 0, 1, 32'h300); step(); chk_pc("t3.s2", 32'h104, 1'b1, 1'b0);
    drive(0, 0, 0, 32'h0);   step(); chk_pc("t3.rel", 32'h300, 1'b1, 1'b0);
    drive(1, 0, 1, 32'h500); step(); chk_pc("t3.s3", 32'h300, 1'b1, 1'b0);
    drive(0, 0, 1, 32'h400); step(); chk_pc("t3.live", 32'h400, 1'b1, 1'b0);
    drive(0, 0, 0, 32'h0);   step(); chk_pc("t3.seq", 32'h404, 1'b1, 1'b0);

    // 4: flush drops same-cycle redirect and parks until a redirect
    drive(0, 1, 1, 32'h80);  step(); chk_pc("t4.fl", FV, 1'b0, 1'b0);
    drive(0, 0, 0, 32'h0);
    step(); chk_pc("t4.w1", FV, 1'b0, 1'b0);
    step(); chk_pc("t4.w2", FV, 1'b0, 1'b0);
    step(); chk_pc("t4.w3", FV, 1'b0, 1'b0);
    drive(0, 0, 1, 32'h80);  step(); chk_pc("t4.redir", 32'h80, 1'b1, 1'b0);

    // 5: stall masks flush; misaligned redirect
    drive(1, 1, 0, 32'h0);   step(); chk_pc("t5.bf", 32'h80, 1'b1, 1'b0);
    drive(0, 0, 1, 32'h102); step(); chk_pc("t5.mis", 32'h100, 1'b1, 1'b1);
    chk("t5.maddr", misalign_addr, 32'h102);
    drive(0, 0, 0, 32'h0);   step(); chk_pc("t5.after", 32'h104, 1'b1, 1'b0);
    chk("t5.maddr_hold", misalign_addr, 32'h102);

    // 6: wraparound, then reset in the middle of HOLD
    drive(0, 0, 1, 32'hFFFF_FFFC); step(); chk_pc("t6.top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    drive(0, 0, 0, 32'h0);   step(); chk_pc("t6.wrap", 32'h0, 1'b1, 1'b0);
    step(); chk_pc("t6.seq", 32'h4, 1'b1, 1'b0);
    drive(1, 0, 1, 32'h700); step(); chk_pc("t6.hold", 32'h4, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk_pc("t6.arst", 32'h0, 1'b0, 1'b0);
    chk("t6.arst_maddr", misalign_addr, 32'h0);
    drive(0, 0, 0, 32'h0);
    #1;
    rst = 1'b0;
    step(); chk_pc("t6.boot", 32'h0, 1'b1, 1'b0);
    step(); chk_pc("t6.seq2", 32'h4, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
